ysyx_25020037_ifu: RTL and testbench

//  Instruction fetch unit: owns the PC, issues one AXI4-Lite read per instruction and

---
 rtl/ysyx_25020037_ifu_pkg.sv | 34 +++
 rtl/ysyx_25020037_ifu.sv | 122 ++++++++++++
 tb/tb_ysyx_25020037_ifu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared fetch-unit types and constants: bus layout, reset PC, AXI response codes.
// No logic; imported by the fetch unit and anything that decodes fu_to_du_bus.
// FSM encoding lives here so decode-side debug tooling can name the states.
package ysyx_25020037_ifu_pkg;

  localparam int          FU_TO_DU_BUS_WD = 64;
  localparam logic [31:0] RESET_PC_DEF    = 32'h3000_0000;
  localparam logic [31:0] ERR_INST_DEF    = 32'hFFFF_FFFF;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_HOLD   = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fu_to_du_t;

  // Error responses are turned into a poison word that decode flags as not-realized.
  function automatic fu_to_du_t make_fu_to_du(input logic [31:0] pc,
                                              input logic [31:0] rdata,
                                              input logic [1:0]  rresp,
                                              input logic [31:0] err_inst);
    fu_to_du_t b;
    b.pc   = pc;
    b.inst = (rresp == AXI_RESP_OKAY) ? rdata : err_inst;
    return b;
  endfunction

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch: owns PC, one AXI4-Lite read per instruction, hands {pc,inst} to decode.
// Latency: accept/redirect -> next arvalid 1 cycle; R beat -> ifu_valid 1 cycle.
// Backpressure: holds ifu_valid/bus stable until idu_ready; at most one read outstanding.
module ysyx_25020037_ifu
  import ysyx_25020037_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] ERR_INST = ERR_INST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       idu_ready,
  output logic                       ifu_valid,
  output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
  input  logic                       exu_dnpc_valid,
  input  logic [31:0]                exu_dnpc,
  output logic                       arvalid,
  input  logic                       arready,
  output logic [31:0]                araddr,
  input  logic                       rvalid,
  output logic                       rready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        flush_q, flush_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        ifu_valid_q, ifu_valid_d;
  fu_to_du_t   bus_q, bus_d;

  logic ar_hs;
  logic r_hs;
  logic drop;

  assign ar_hs = arvalid_q & arready;
  assign r_hs  = rready_q & rvalid;
  // A redirect landing in the same cycle as the R beat makes that beat stale too.
  assign drop  = flush_q | exu_dnpc_valid;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      flush_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ifu_valid_q <= 1'b0;
      bus_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      flush_q     <= flush_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ifu_valid_q <= ifu_valid_d;
      bus_q       <= bus_d;
    end
  end

  // Next-state: redirect in HOLD pre-empts the accept, so both go straight back to REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    if (ar_hs) state_d = S_WAIT_R;
      S_WAIT_R: if (r_hs) state_d = drop ? S_REQ : S_HOLD;
      S_HOLD:   if (exu_dnpc_valid || idu_ready) state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  // PC, request address and flush tracking.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    flush_d    = flush_q;

    // Latest redirect wins; sequential pc+4 only on a clean accept.
    if (exu_dnpc_valid) begin
      pc_d = exu_dnpc;
    end else if (state_q == S_HOLD && idu_ready) begin
      pc_d = pc_q + 32'd4;
    end

    // araddr is frozen while in REQ so an unaccepted AR never changes under the slave.
    if (state_d == S_REQ && state_q != S_REQ) begin
      req_addr_d = pc_d;
    end

    // The one outstanding (or about-to-issue) read is now stale; eat its R beat.
    if (state_q == S_WAIT_R && r_hs) begin
      flush_d = 1'b0;
    end else if (exu_dnpc_valid && (state_q == S_REQ || state_q == S_WAIT_R)) begin
      flush_d = 1'b1;
    end
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    arvalid_d   = (state_d == S_REQ);
    rready_d    = (state_d == S_WAIT_R);
    ifu_valid_d = (state_d == S_HOLD);
    bus_d       = bus_q;
    if (state_q == S_WAIT_R && r_hs && !drop) begin
      bus_d = make_fu_to_du(req_addr_q, rdata, rresp, ERR_INST);
    end
  end

  assign arvalid      = arvalid_q;
  assign araddr       = req_addr_q;
  assign rready       = rready_q;
  assign ifu_valid    = ifu_valid_q;
  assign fu_to_du_bus = bus_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the fetch unit: bench plays AXI slave and decode stage.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ysyx_25020037_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idu_ready = 1'b0;
  logic        ifu_valid;
  logic [63:0] fu_to_du_bus;
  logic        exu_dnpc_valid = 1'b0;
  logic [31:0] exu_dnpc = '0;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;

  int n_vec = 0;
  int n_err = 0;

  ysyx_25020037_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .idu_ready      (idu_ready),
    .ifu_valid      (ifu_valid),
    .fu_to_du_bus   (fu_to_du_bus),
    .exu_dnpc_valid (exu_dnpc_valid),
    .exu_dnpc       (exu_dnpc),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rresp          (rresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an AR, check its address, handshake, then return one R beat.
  // Returns on the falling edge right after the R beat was sampled.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                       input logic [1:0] resp, input string tag);
    int k;
    k = 0;
    while (!arvalid && k < 20) begin @(negedge clk); k++; end
    check({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    check({tag, "_araddr"}, 64'(araddr), 64'(exp_addr));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    k = 0;
    while (!rready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_rready"}, 64'(rready), 64'd1);
    rvalid = 1'b1; rdata = data; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0; rresp = '0;
  endtask

  task automatic accept();
    idu_ready = 1'b1;
    @(negedge clk);
    idu_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    exu_dnpc_valid = 1'b1; exu_dnpc = tgt;
    @(negedge clk);
    exu_dnpc_valid = 1'b0; exu_dnpc = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_ifu_valid", 64'(ifu_valid), 64'd0);
    check("rst_bus", fu_to_du_bus, 64'd0);
    rst = 1'b0;

    // 1: first fetch from the reset PC.
    fetch(32'h3000_0000, 32'h0000_0413, 2'b00, "t1");
    check("t1_ifu_valid", 64'(ifu_valid), 64'd1);
    check("t1_bus", fu_to_du_bus, 64'h3000_0000_0000_0413);

    // 2: decode stalls for 5 cycles; everything holds, no new AR.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 64'(ifu_valid), 64'd1);
      check("t2_hold_bus", fu_to_du_bus, 64'h3000_0000_0000_0413);
      check("t2_hold_noar", 64'(arvalid), 64'd0);
    end
    accept();
    check("t2_valid_drop", 64'(ifu_valid), 64'd0);
    check("t2_ar_latency", 64'(arvalid), 64'd1);
    fetch(32'h3000_0004, 32'h0010_0093, 2'b00, "t2");
    check("t2_bus", fu_to_du_bus, 64'h3000_0004_0010_0093);
    accept();

    // 3: redirect while waiting for R; late beat is dropped.
    check("t3_araddr", 64'(araddr), 64'h3000_0008);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("t3_rready", 64'(rready), 64'd1);
    redirect(32'h3000_0100);
    @(negedge clk);
    check("t3_no_valid", 64'(ifu_valid), 64'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    check("t3_dropped", 64'(ifu_valid), 64'd0);
    check("t3_bus_kept", fu_to_du_bus, 64'h3000_0004_0010_0093);
    fetch(32'h3000_0100, 32'h0020_0113, 2'b00, "t3");
    check("t3_bus", fu_to_du_bus, 64'h3000_0100_0020_0113);

    // 4a: redirect in HOLD together with idu_ready; redirect wins.
    idu_ready = 1'b1;
    redirect(32'h3000_0200);
    idu_ready = 1'b0;
    check("t4a_valid", 64'(ifu_valid), 64'd0);
    check("t4a_arvalid", 64'(arvalid), 64'd1);
    check("t4a_araddr", 64'(araddr), 64'h3000_0200);
    fetch(32'h3000_0200, 32'h0030_0193, 2'b00, "t4a");
    check("t4a_bus", fu_to_du_bus, 64'h3000_0200_0030_0193);
    accept();

    // 4b: redirect while AR is pending without arready; AR stays put, then beat dropped.
    check("t4b_araddr0", 64'(araddr), 64'h3000_0204);
    redirect(32'h3000_0300);
    check("t4b_arvalid1", 64'(arvalid), 64'd1);
    check("t4b_araddr1", 64'(araddr), 64'h3000_0204);
    @(negedge clk);
    check("t4b_araddr2", 64'(araddr), 64'h3000_0204);
    fetch(32'h3000_0204, 32'hBAD0_BAD0, 2'b00, "t4b_stale");
    check("t4b_dropped", 64'(ifu_valid), 64'd0);
    check("t4b_re_ar", 64'(araddr), 64'h3000_0300);
    fetch(32'h3000_0300, 32'h0040_0213, 2'b00, "t4b");
    check("t4b_bus", fu_to_du_bus, 64'h3000_0300_0040_0213);
    accept();

    // 5: access error becomes the poison instruction at the request address.
    fetch(32'h3000_0304, 32'h1234_5678, 2'b10, "t5");
    check("t5_valid", 64'(ifu_valid), 64'd1);
    check("t5_bus", fu_to_du_bus, 64'h3000_0304_FFFF_FFFF);

    // PC wrap: redirect to the top word, accept, next fetch at 0.
    redirect(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 2'b00, "wrap");
    check("wrap_bus", fu_to_du_bus, 64'hFFFF_FFFC_0000_0013);
    accept();
    check("wrap_araddr", 64'(araddr), 64'h0000_0000);

    // 6: reset asserted mid-read clears outputs immediately, refetch from reset PC.
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("t6_rready", 64'(rready), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_arvalid", 64'(arvalid), 64'd0);
    check("t6_rready0", 64'(rready), 64'd0);
    check("t6_valid", 64'(ifu_valid), 64'd0);
    check("t6_bus", fu_to_du_bus, 64'd0);
    check("t6_araddr", 64'(araddr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h3000_0000, 32'h0000_0413, 2'b00, "t6");
    check("t6_refetch_bus", fu_to_du_bus, 64'h3000_0000_0000_0413);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
